// File: rtl/rv32_pkg.sv
// Shared fetch-path definitions.
//   fetch_state_e    : fetch sequencer states
//   NOP_INST         : addi x0,x0,0, presented on bubbles
//   RESET_PC_DEFAULT : default first fetch address
package rv32_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Control-flow target selection for the instruction on pc.
// Ports:
//   i_pc, i_al, i_ujimm, i_sbimm : byte PC, ALU result, J-type and B-type offsets
//   i_jalr, i_uj_en, i_b_en      : control-flow flags for the instruction on pc
//   o_req                        : any control-flow flag set (qualified by the caller)
//   o_target                     : redirect target, priority jalr > jal > branch
module next_pc_sel
  import rv32_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_jalr,
  input  logic        i_uj_en,
  input  logic        i_b_en,
  input  logic [31:0] i_al,
  input  logic [31:0] i_ujimm,
  input  logic [31:0] i_sbimm,
  output logic        o_req,
  output logic [31:0] o_target
);

  logic [31:0] w_uj_target;
  logic [31:0] w_b_target;

  assign w_uj_target = i_pc + i_ujimm;
  assign w_b_target  = i_pc + i_sbimm;
  assign o_req       = i_jalr | i_uj_en | i_b_en;

  always_comb begin
    o_target = w_b_target;
    if (i_jalr) begin
      o_target = i_al & ~32'h1;
    end else if (i_uj_en) begin
      o_target = w_uj_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives a synchronous instruction memory
// (1-cycle read latency) and hands pc/inst/inst_valid to decode. A redirect inserts one bubble.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_stall                   : decode back-pressure, hold pc/inst
//   i_b_en, i_uj_en, i_jalr   : taken branch / JAL / JALR for the instruction on o_pc
//   i_al, i_ujimm, i_sbimm    : JALR base, J-type and B-type offsets
//   o_imem_adr, o_imem_en     : instmem word address and read enable
//   i_imem_data               : instmem data_out
//   o_inst, o_pc, o_inst_valid: instruction triple to decode
module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_b_en,
  input  logic              i_uj_en,
  input  logic              i_jalr,
  input  logic [31:0]       i_al,
  input  logic [31:0]       i_ujimm,
  input  logic [31:0]       i_sbimm,
  output logic [ADDR_W-1:0] o_imem_adr,
  output logic              o_imem_en,
  input  logic [31:0]       i_imem_data,
  output logic [31:0]       o_inst,
  output logic [31:0]       o_pc,
  output logic              o_inst_valid
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_pc;
  logic [31:0]  w_fetch_pc_next;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_seq_pc;
  logic [31:0]  w_target;
  logic [31:0]  w_target_seq;
  logic         w_flag;
  logic         w_redirect;

  next_pc_sel u_next_pc_sel (
    .i_pc     (r_pc),
    .i_jalr   (i_jalr),
    .i_uj_en  (i_uj_en),
    .i_b_en   (i_b_en),
    .i_al     (i_al),
    .i_ujimm  (i_ujimm),
    .i_sbimm  (i_sbimm),
    .o_req    (w_flag),
    .o_target (w_target)
  );

  assign w_seq_pc     = r_fetch_pc + 32'd4;
  assign w_target_seq = w_target + 32'd4;
  // Flags only mean something while a real instruction sits on pc.
  assign w_redirect   = w_flag && (r_state == RUN);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pc_next       = r_pc;
    o_imem_en       = 1'b0;
    o_imem_adr      = r_fetch_pc[ADDR_W+1:2];
    o_inst_valid    = 1'b0;
    unique case (r_state)
      BOOT: begin
        o_imem_en       = 1'b1;
        o_imem_adr      = RESET_PC[ADDR_W+1:2];
        w_fetch_pc_next = RESET_PC + 32'd4;
        w_pc_next       = RESET_PC;
        w_state_next    = RUN;
      end
      RUN: begin
        o_inst_valid = 1'b1;
        if (w_redirect) begin
          // Redirect wins over stall: fetch the target now, squash the word in flight.
          o_imem_en       = 1'b1;
          o_imem_adr      = w_target[ADDR_W+1:2];
          w_pc_next       = w_target;
          w_fetch_pc_next = w_target_seq;
          w_state_next    = SQUASH;
        end else if (!i_stall) begin
          o_imem_en       = 1'b1;
          w_pc_next       = r_fetch_pc;
          w_fetch_pc_next = w_seq_pc;
        end
      end
      SQUASH: begin
        // Target word is already in instmem's output register; keep it for RUN.
        o_imem_adr   = r_pc[ADDR_W+1:2];
        w_state_next = RUN;
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  assign o_inst = o_inst_valid ? i_imem_data : NOP;
  assign o_pc   = r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pc       <= w_pc_next;
    end
  end

endmodule
